result_tx: RTL and testbench

Result streamer on the output side of the search top. It watches the registered best-so-far `progress`/`msg` pair that the top level produces. Whenever `progress` improves on the last value reported, it snapshots the pair and serializes it as a byte frame on a valid/ready stream toward the host link. It is the transmit end of the result path; the host-side parser is the receiver.

---
 rtl/result_tx.sv | 122 ++++++++++++
 tb/tb_result_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_tx.sv
// Result streamer: snapshots the best-so-far progress/msg pair whenever progress
// improves and serializes it as a framed byte stream on a valid/ready link.
module result_tx #(
  parameter int         MSG = 512,
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [8:0]     progress_i,
  input  logic [MSG-1:0] msg_i,
  output logic           tx_valid_o,
  output logic [7:0]     tx_data_o,
  input  logic           tx_ready_i,
  output logic           busy_o,
  output logic [15:0]    frames_o
);

  localparam int NB    = MSG / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NB - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PROG = 3'd2;
  localparam logic [2:0] S_MSG  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [8:0]       sent_q, sent_d;
  logic [MSG-1:0]   snap_q, snap_d;
  logic [7:0]       prog_q, prog_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       chk_q, chk_d;
  logic [15:0]      frames_q, frames_d;
  logic             hs;
  logic [7:0]       msg_byte;

  // The snapshot shifts left per accepted byte, so the current byte is always the top one.
  assign msg_byte   = snap_q[MSG-1 -: 8];
  assign tx_valid_o = (state_q != S_IDLE);
  assign busy_o     = (state_q != S_IDLE);
  assign frames_o   = frames_q;
  assign hs         = tx_valid_o && tx_ready_i;

  always_comb begin
    tx_data_o = 8'd0;
    case (state_q)
      S_HDR:   tx_data_o = HDR;
      S_PROG:  tx_data_o = prog_q;
      S_MSG:   tx_data_o = msg_byte;
      S_CHK:   tx_data_o = chk_q;
      default: tx_data_o = 8'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sent_d   = sent_q;
    snap_d   = snap_q;
    prog_d   = prog_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    frames_d = frames_q;
    case (state_q)
      S_IDLE: begin
        // Only the latest value is reported; intermediate improvements are dropped.
        if (progress_i > sent_q) begin
          snap_d  = msg_i;
          prog_d  = progress_i[7:0];
          sent_d  = progress_i;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (hs) state_d = S_PROG;
      end
      S_PROG: begin
        if (hs) begin
          chk_d   = prog_q;
          idx_d   = '0;
          state_d = S_MSG;
        end
      end
      S_MSG: begin
        if (hs) begin
          chk_d  = chk_q ^ msg_byte;
          snap_d = snap_q << 8;
          if (idx_q == LAST) state_d = S_CHK;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      S_CHK: begin
        if (hs) begin
          frames_d = frames_q + 16'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      sent_q   <= '0;
      snap_q   <= '0;
      prog_q   <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      sent_q   <= sent_d;
      snap_q   <= snap_d;
      prog_q   <= prog_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_result_tx.sv
// Scoreboard bench for result_tx: stimulus queues expected frame bytes, a
// negedge monitor pops and compares every accepted byte.
module tb_result_tx;
  localparam int MSG = 512;
  localparam int NB  = MSG / 8;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic [8:0]     progress_i = '0;
  logic [MSG-1:0] msg_i = '0;
  logic           tx_valid_o;
  logic [7:0]     tx_data_o;
  logic           tx_ready_i = 1'b1;
  logic           busy_o;
  logic [15:0]    frames_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  result_tx #(.MSG(MSG), .HDR(8'hA5)) dut (
    .clk_i(clk), .reset_i(reset_i), .progress_i(progress_i), .msg_i(msg_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .frames_o(frames_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte k (MSB-first) of the message is base ^ k.
  function automatic logic [MSG-1:0] mk_msg(input logic [7:0] base);
    logic [MSG-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) m[MSG-1-8*k -: 8] = base ^ 8'(k);
    return m;
  endfunction

  task automatic push_frame(input logic [7:0] prog, input logic [MSG-1:0] m);
    logic [7:0] c;
    c = prog;
    exp_q.push_back(8'hA5);
    exp_q.push_back(prog);
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(m[MSG-1-8*k -: 8]);
      c = c ^ m[MSG-1-8*k -: 8];
    end
    exp_q.push_back(c);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      step(1);
      n++;
    end
    check({name, "_timeout"}, int'(busy_o), 0);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: compare accepted bytes against the scoreboard; check stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;
  always @(negedge clk) begin
    if (!reset_i && prev_stall) begin
      check("stall_valid", int'(tx_valid_o), 1);
      check("stall_data", int'(tx_data_o), int'(prev_data));
    end
    if (!reset_i && tx_valid_o && tx_ready_i) begin
      if (exp_q.size() == 0) check("unexpected_byte", int'(tx_data_o), -1);
      else check("stream_byte", int'(tx_data_o), int'(exp_q.pop_front()));
    end
    prev_stall = !reset_i && tx_valid_o && !tx_ready_i;
    prev_data  = tx_data_o;
  end

  logic [MSG-1:0] msg_a, msg_b, msg_c;
  bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int cnt;
    msg_a = mk_msg(8'h00);
    msg_b = mk_msg(8'h5A);
    msg_c = mk_msg(8'hC3);

    // Reset state
    step(2);
    reset_i = 1'b0;
    step(1);
    check("rst_valid", int'(tx_valid_o), 0);
    check("rst_data", int'(tx_data_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_frames", int'(frames_o), 0);
    step(2);
    check("zero_no_frame", int'(tx_valid_o), 0);

    // Single frame, ready held high: A5 25 00..3F 25
    msg_i = msg_a;
    progress_i = 9'd37;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h25);
    for (int k = 0; k < NB; k++) exp_q.push_back(8'(k));
    exp_q.push_back(8'h25);
    step(1);
    check("lat_valid", int'(tx_valid_o), 1);
    check("lat_hdr", int'(tx_data_o), 'hA5);
    cnt = 0;
    while (tx_valid_o && cnt < 200) begin
      step(1);
      cnt++;
    end
    check("frame_len", cnt, 67);
    check("single_frames", int'(frames_o), 1);
    check("single_busy", int'(busy_o), 0);
    check("single_drained", exp_q.size(), 0);

    // Backpressure: same frame with ready pattern 1,0,0,1
    reset_i = 1'b1;
    progress_i = 9'd0;
    step(1);
    reset_i = 1'b0;
    progress_i = 9'd37;
    push_frame(8'h25, msg_a);
    cnt = 0;
    step(1);
    while (busy_o && cnt < 400) begin
      tx_ready_i = pat[cnt % 4];
      step(1);
      cnt++;
    end
    tx_ready_i = 1'b1;
    check("bp_done", int'(busy_o), 0);
    check("bp_frames", int'(frames_o), 1);
    check("bp_drained", exp_q.size(), 0);

    // Mid-frame improvements: only the latest (61) is reported next
    reset_i = 1'b1;
    progress_i = 9'd0;
    step(1);
    reset_i = 1'b0;
    progress_i = 9'd37;
    msg_i = msg_a;
    push_frame(8'h25, msg_a);
    step(6);
    progress_i = 9'd50;
    msg_i = msg_b;
    step(10);
    progress_i = 9'd61;
    msg_i = msg_c;
    push_frame(8'h3D, msg_c);
    cnt = 0;
    while (frames_o != 16'd1 && cnt < 200) begin
      step(1);
      cnt++;
    end
    check("mid_first_done", int'(frames_o), 1);
    check("mid_gap_idle", int'(tx_valid_o), 0);
    step(1);
    check("mid_second_hdr", int'(tx_data_o), 'hA5);
    step(1);
    check("mid_second_prog", int'(tx_data_o), 'h3D);
    wait_idle("mid", 200);
    check("mid_frames", int'(frames_o), 2);

    // Non-improvement: equal then lower progress
    msg_i = msg_b;
    step(3);
    check("eq_no_valid", int'(tx_valid_o), 0);
    progress_i = 9'd40;
    msg_i = msg_a;
    step(5);
    check("dec_no_valid", int'(tx_valid_o), 0);
    check("dec_frames", int'(frames_o), 2);

    // Reset mid-frame at message byte 10
    progress_i = 9'd61;
    msg_i = msg_c;
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    push_frame(8'h3D, msg_c);
    step(1);
    check("rm_hdr", int'(tx_data_o), 'hA5);
    step(12);
    check("rm_byte10", int'(tx_data_o), int'(8'hC3 ^ 8'd10));
    reset_i = 1'b1;
    step(1);
    exp_q.delete();
    check("rm_valid", int'(tx_valid_o), 0);
    check("rm_frames", int'(frames_o), 0);
    reset_i = 1'b0;
    push_frame(8'h3D, msg_c);
    step(1);
    check("rm_restart_hdr", int'(tx_data_o), 'hA5);
    step(1);
    check("rm_restart_prog", int'(tx_data_o), 'h3D);
    wait_idle("rm", 200);
    check("rm_frames_after", int'(frames_o), 1);

    // Counter wrap with the frame counter preloaded
    force dut.frames_q = 16'hFFFF;
    step(1);
    release dut.frames_q;
    step(1);
    check("wrap_preload", int'(frames_o), 'hFFFF);
    progress_i = 9'd62;
    msg_i = msg_b;
    push_frame(8'h3E, msg_b);
    step(1);
    wait_idle("wrap", 200);
    check("wrap_frames", int'(frames_o), 0);

    step(2);
    check("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
